framebuf_pingpong: RTL and testbench

FRAMEBUF_PINGPONG -- requirements
Module: framebuf_pingpong

---
 rtl/framebuf_pingpong_if.sv | 37 +++
 rtl/framebuf_pingpong.sv | 145 ++++++++++++++
 tb/tb_framebuf_pingpong.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/framebuf_pingpong_if.sv
// Memory-port bundle for the ping-pong frame buffer: writer port s1 (back bank)
// and read-only display port s2 (front bank).
interface framebuf_pingpong_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] mem_s1_address;
    logic              mem_s1_chipselect;
    logic              mem_s1_clken;
    logic              mem_s1_write;
    logic [DATA_W-1:0] mem_s1_writedata;
    logic [BE_W-1:0]   mem_s1_byteenable;
    logic [DATA_W-1:0] mem_s1_readdata;

    logic [ADDR_W-1:0] mem_s2_address;
    logic              mem_s2_chipselect;
    logic              mem_s2_clken;
    logic [DATA_W-1:0] mem_s2_readdata;

    modport master (
        output mem_s1_address, mem_s1_chipselect, mem_s1_clken, mem_s1_write,
        output mem_s1_writedata, mem_s1_byteenable,
        input  mem_s1_readdata,
        output mem_s2_address, mem_s2_chipselect, mem_s2_clken,
        input  mem_s2_readdata
    );

    modport slave (
        input  mem_s1_address, mem_s1_chipselect, mem_s1_clken, mem_s1_write,
        input  mem_s1_writedata, mem_s1_byteenable,
        output mem_s1_readdata,
        input  mem_s2_address, mem_s2_chipselect, mem_s2_clken,
        output mem_s2_readdata
    );
endinterface

// File: rtl/framebuf_pingpong.sv
// Two-bank ping-pong frame buffer: s1 writes/reads the back bank, s2 reads the
// front bank, and a vsync-synchronised FSM exchanges the banks on request.
module framebuf_pingpong #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
) (
    input  logic                 mem_clk_clk,
    input  logic                 mem_rst_reset,
    framebuf_pingpong_if.slave   bus,
    input  logic                 swap_req,
    input  logic                 vsync,
    output logic                 swap_pending,
    output logic                 swap_done,
    output logic                 front_sel
);
    localparam int BE_W  = DATA_W / 8;
    localparam int WORDS = 2 * (1 << ADDR_W);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic              front_sel_r;
    logic              front_sel_s;
    logic              swap_pending_r;
    logic              swap_pending_s;
    logic              swap_done_r;
    logic              swap_done_s;
    logic [DATA_W-1:0] s1_readdata_r;
    logic [DATA_W-1:0] s2_readdata_r;

    // Both banks share one array; the bank index is the top address bit.
    logic [DATA_W-1:0] mem_r [0:WORDS-1];

    logic [ADDR_W:0] s1_idx_s;
    logic [ADDR_W:0] s2_idx_s;
    logic            s1_wr_s;
    logic            s1_rd_s;
    logic            s2_rd_s;

    assign s1_idx_s = {~front_sel_r, bus.mem_s1_address};
    assign s2_idx_s = { front_sel_r, bus.mem_s2_address};
    assign s1_wr_s  = ~mem_rst_reset & bus.mem_s1_chipselect & bus.mem_s1_clken &  bus.mem_s1_write;
    assign s1_rd_s  = ~mem_rst_reset & bus.mem_s1_chipselect & bus.mem_s1_clken & ~bus.mem_s1_write;
    assign s2_rd_s  = ~mem_rst_reset & bus.mem_s2_chipselect & bus.mem_s2_clken;

    // Byte-masked back-bank writes; contents survive reset.
    always_ff @(posedge mem_clk_clk) begin
        if (s1_wr_s) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.mem_s1_byteenable[i]) begin
                    mem_r[s1_idx_s][i*8 +: 8] <= bus.mem_s1_writedata[i*8 +: 8];
                end
            end
        end
    end

    // Registered read data for both ports; holds when the port is idle.
    always_ff @(posedge mem_clk_clk) begin
        if (mem_rst_reset) begin
            s1_readdata_r <= {DATA_W{1'b0}};
            s2_readdata_r <= {DATA_W{1'b0}};
        end else begin
            if (s1_rd_s) begin
                s1_readdata_r <= mem_r[s1_idx_s];
            end else begin
                s1_readdata_r <= s1_readdata_r;
            end
            if (s2_rd_s) begin
                s2_readdata_r <= mem_r[s2_idx_s];
            end else begin
                s2_readdata_r <= s2_readdata_r;
            end
        end
    end

    // Swap FSM state and registered status outputs.
    always_ff @(posedge mem_clk_clk) begin
        if (mem_rst_reset) begin
            state_r        <= ST_IDLE;
            front_sel_r    <= 1'b0;
            swap_pending_r <= 1'b0;
            swap_done_r    <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            front_sel_r    <= front_sel_s;
            swap_pending_r <= swap_pending_s;
            swap_done_r    <= swap_done_s;
        end
    end

    // Next-state logic; a request seen while PENDING is deliberately dropped.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (swap_req && vsync) begin
                    next_state_s = ST_SWAP;
                end else if (swap_req) begin
                    next_state_s = ST_PENDING;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (vsync) begin
                    next_state_s = ST_SWAP;
                end else begin
                    next_state_s = ST_PENDING;
                end
            end
            ST_SWAP: begin
                if (swap_req) begin
                    next_state_s = ST_PENDING;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Status outputs are computed from the next state so the registers
    // line up with the state they describe; front_sel flips on SWAP exit.
    always_comb begin
        swap_pending_s = (next_state_s != ST_IDLE);
        swap_done_s    = (next_state_s == ST_SWAP);
        if (state_r == ST_SWAP) begin
            front_sel_s = ~front_sel_r;
        end else begin
            front_sel_s = front_sel_r;
        end
    end

    assign swap_pending        = swap_pending_r;
    assign swap_done           = swap_done_r;
    assign front_sel           = front_sel_r;
    assign bus.mem_s1_readdata = s1_readdata_r;
    assign bus.mem_s2_readdata = s2_readdata_r;
endmodule

// File: tb/tb_framebuf_pingpong.sv
// Directed self-checking bench for framebuf_pingpong: byte writes, bank swap
// timing, port hold behaviour and reset during a swap.
module tb_framebuf_pingpong;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 13;

    logic clk;
    logic rst;
    logic swap_req;
    logic vsync;
    logic swap_pending;
    logic swap_done;
    logic front_sel;

    int checks;
    int errors;

    framebuf_pingpong_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    framebuf_pingpong #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .mem_clk_clk   (clk),
        .mem_rst_reset (rst),
        .bus           (bus),
        .swap_req      (swap_req),
        .vsync         (vsync),
        .swap_pending  (swap_pending),
        .swap_done     (swap_done),
        .front_sel     (front_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        bus.mem_s1_chipselect = 1'b0;
        bus.mem_s1_clken      = 1'b0;
        bus.mem_s1_write      = 1'b0;
        bus.mem_s1_byteenable = 2'b00;
        bus.mem_s2_chipselect = 1'b0;
        bus.mem_s2_clken      = 1'b0;
    endtask

    task automatic s1_write(input logic [12:0] addr, input logic [15:0] data,
                            input logic [1:0] be, input logic clken);
        bus.mem_s1_address    = addr;
        bus.mem_s1_writedata  = data;
        bus.mem_s1_byteenable = be;
        bus.mem_s1_chipselect = 1'b1;
        bus.mem_s1_clken      = clken;
        bus.mem_s1_write      = 1'b1;
        tick();
        idle_ports();
    endtask

    task automatic s1_read(input logic [12:0] addr);
        bus.mem_s1_address    = addr;
        bus.mem_s1_chipselect = 1'b1;
        bus.mem_s1_clken      = 1'b1;
        bus.mem_s1_write      = 1'b0;
        tick();
        idle_ports();
    endtask

    task automatic s2_read(input logic [12:0] addr, input logic cs, input logic clken);
        bus.mem_s2_address    = addr;
        bus.mem_s2_chipselect = cs;
        bus.mem_s2_clken      = clken;
        tick();
        idle_ports();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel: got %b expected 0", front_sel); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_swap_pending: got %b expected 0", swap_pending); end
        checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL reset_swap_done: got %b expected 0", swap_done); end
        checks++; if (bus.mem_s1_readdata !== 16'h0000) begin errors++; $display("FAIL reset_s1_readdata: got %h expected 0000", bus.mem_s1_readdata); end
        checks++; if (bus.mem_s2_readdata !== 16'h0000) begin errors++; $display("FAIL reset_s2_readdata: got %h expected 0000", bus.mem_s2_readdata); end
    endtask

    task automatic test_byte_write();
        s1_write(13'd5, 16'hA5C3, 2'b11, 1'b1);
        checks++; if (bus.mem_s1_readdata !== 16'h0000) begin errors++; $display("FAIL write_no_readdata: got %h expected 0000", bus.mem_s1_readdata); end
        s1_write(13'd5, 16'h00FF, 2'b01, 1'b1);
        s1_read(13'd5);
        checks++; if (bus.mem_s1_readdata !== 16'hA5FF) begin errors++; $display("FAIL byte_merge: got %h expected a5ff", bus.mem_s1_readdata); end
        s1_write(13'd7, 16'hBEEF, 2'b11, 1'b1);
        checks++; if (bus.mem_s1_readdata !== 16'hA5FF) begin errors++; $display("FAIL write_holds_readdata: got %h expected a5ff", bus.mem_s1_readdata); end
        s1_read(13'd7);
        checks++; if (bus.mem_s1_readdata !== 16'hBEEF) begin errors++; $display("FAIL s1_read_addr7: got %h expected beef", bus.mem_s1_readdata); end
    endtask

    task automatic test_swap_delayed();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL delayed_pending_first: got %b expected 1", swap_pending); end
        checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL delayed_done_early: got %b expected 0", swap_done); end
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++; if (swap_pending !== 1'b1 || swap_done !== 1'b0 || front_sel !== 1'b0) begin
                errors++; $display("FAIL delayed_wait_%0d: pending %b done %b front %b expected 1 0 0", i, swap_pending, swap_done, front_sel);
            end
        end
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        checks++; if (swap_done !== 1'b1 || swap_pending !== 1'b1) begin errors++; $display("FAIL delayed_swap_cycle: done %b pending %b expected 1 1", swap_done, swap_pending); end
        checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL delayed_front_in_swap: got %b expected 0", front_sel); end
        // Read issued during the SWAP cycle still targets the old back bank.
        s1_read(13'd5);
        checks++; if (bus.mem_s1_readdata !== 16'hA5FF) begin errors++; $display("FAIL swap_edge_old_map: got %h expected a5ff", bus.mem_s1_readdata); end
        checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL delayed_front_after: got %b expected 1", front_sel); end
        checks++; if (swap_done !== 1'b0 || swap_pending !== 1'b0) begin errors++; $display("FAIL delayed_idle_after: done %b pending %b expected 0 0", swap_done, swap_pending); end
        s2_read(13'd7, 1'b1, 1'b1);
        checks++; if (bus.mem_s2_readdata !== 16'hBEEF) begin errors++; $display("FAIL s2_reads_new_front7: got %h expected beef", bus.mem_s2_readdata); end
        s2_read(13'd5, 1'b1, 1'b1);
        checks++; if (bus.mem_s2_readdata !== 16'hA5FF) begin errors++; $display("FAIL s2_reads_new_front5: got %h expected a5ff", bus.mem_s2_readdata); end
    endtask

    task automatic test_swap_immediate();
        s1_write(13'd3, 16'h1357, 2'b11, 1'b1);
        swap_req = 1'b1;
        vsync    = 1'b1;
        tick();
        swap_req = 1'b0;
        vsync    = 1'b0;
        checks++; if (swap_done !== 1'b1 || swap_pending !== 1'b1) begin errors++; $display("FAIL imm_swap_cycle: done %b pending %b expected 1 1", swap_done, swap_pending); end
        tick();
        checks++; if (swap_done !== 1'b0 || swap_pending !== 1'b0) begin errors++; $display("FAIL imm_after: done %b pending %b expected 0 0", swap_done, swap_pending); end
        checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL imm_front: got %b expected 0", front_sel); end
        s2_read(13'd3, 1'b1, 1'b1);
        checks++; if (bus.mem_s2_readdata !== 16'h1357) begin errors++; $display("FAIL imm_s2_data: got %h expected 1357", bus.mem_s2_readdata); end
    endtask

    task automatic test_back_to_back();
        swap_req = 1'b1;
        tick();
        tick();
        swap_req = 1'b0;
        checks++; if (swap_pending !== 1'b1 || swap_done !== 1'b0) begin errors++; $display("FAIL b2b_pending: pending %b done %b expected 1 0", swap_pending, swap_done); end
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", swap_done); end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        checks++; if (swap_pending !== 1'b1 || swap_done !== 1'b0 || front_sel !== 1'b1) begin
            errors++; $display("FAIL b2b_requeue: pending %b done %b front %b expected 1 0 1", swap_pending, swap_done, front_sel);
        end
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected 1", swap_done); end
        tick();
        checks++; if (front_sel !== 1'b0 || swap_pending !== 1'b0 || swap_done !== 1'b0) begin
            errors++; $display("FAIL b2b_final: front %b pending %b done %b expected 0 0 0", front_sel, swap_pending, swap_done);
        end
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        checks++; if (front_sel !== 1'b0 || swap_pending !== 1'b0 || swap_done !== 1'b0) begin
            errors++; $display("FAIL lone_vsync: front %b pending %b done %b expected 0 0 0", front_sel, swap_pending, swap_done);
        end
    endtask

    task automatic test_port_hold();
        s2_read(13'd7, 1'b1, 1'b0);
        checks++; if (bus.mem_s2_readdata !== 16'h1357) begin errors++; $display("FAIL s2_hold_clken: got %h expected 1357", bus.mem_s2_readdata); end
        s2_read(13'd7, 1'b0, 1'b1);
        checks++; if (bus.mem_s2_readdata !== 16'h1357) begin errors++; $display("FAIL s2_hold_cs: got %h expected 1357", bus.mem_s2_readdata); end
        s1_write(13'd5, 16'h0000, 2'b11, 1'b0);
        s1_read(13'd5);
        checks++; if (bus.mem_s1_readdata !== 16'hA5FF) begin errors++; $display("FAIL s1_write_clken0: got %h expected a5ff", bus.mem_s1_readdata); end
    endtask

    task automatic test_reset_mid_swap();
        swap_req = 1'b1;
        vsync    = 1'b1;
        tick();
        tick();
        checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL rst_setup_front: got %b expected 1", front_sel); end
        tick();
        swap_req = 1'b0;
        vsync    = 1'b0;
        checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL rst_in_swap: got %b expected 1", swap_done); end
        rst      = 1'b1;
        swap_req = 1'b1;
        tick();
        rst      = 1'b0;
        swap_req = 1'b0;
        checks++; if (front_sel !== 1'b0 || swap_done !== 1'b0 || swap_pending !== 1'b0) begin
            errors++; $display("FAIL rst_mid_swap: front %b done %b pending %b expected 0 0 0", front_sel, swap_done, swap_pending);
        end
        checks++; if (bus.mem_s1_readdata !== 16'h0000 || bus.mem_s2_readdata !== 16'h0000) begin
            errors++; $display("FAIL rst_readdata: s1 %h s2 %h expected 0000 0000", bus.mem_s1_readdata, bus.mem_s2_readdata);
        end
        tick();
        checks++; if (swap_pending !== 1'b0 || front_sel !== 1'b0) begin errors++; $display("FAIL rst_stays_idle: pending %b front %b expected 0 0", swap_pending, front_sel); end
        s2_read(13'd3, 1'b1, 1'b1);
        checks++; if (bus.mem_s2_readdata !== 16'h1357) begin errors++; $display("FAIL rst_retain_bank0: got %h expected 1357", bus.mem_s2_readdata); end
        s1_read(13'd5);
        checks++; if (bus.mem_s1_readdata !== 16'hA5FF) begin errors++; $display("FAIL rst_retain_bank1: got %h expected a5ff", bus.mem_s1_readdata); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        swap_req = 1'b0;
        vsync    = 1'b0;
        bus.mem_s1_address   = 13'd0;
        bus.mem_s1_writedata = 16'h0000;
        bus.mem_s2_address   = 13'd0;
        idle_ports();

        test_reset();
        test_byte_write();
        test_swap_delayed();
        test_swap_immediate();
        test_back_to_back();
        test_port_hold();
        test_reset_mid_swap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
